counter_checker: RTL and testbench
==================================

Name: counter_checker

Overview:
- Passive sequence checker for the 4-bit enable counter. It sits on the same clock beside the counter and watches the counter's control inputs (cnt_rst, enable) and its output (count_in).
- On every rising edge it predicts the counter's next value and compares it with what the counter actually produces.
- It reports lock status, single-cycle error pulses, wrap events and a saturating error count. It is used in lab benches and in on-board self-check.

Parameters:
- WIDTH, 4, counter output width; the counter wraps modulo 2^WIDTH.
- ERR_W, 8, width of the error counter.
- LOCK_CYCLES, 2, consecutive correct predictions needed to declare lock (at least 1).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high checker reset.
- cnt_rst  input  1  synchronous reset as driven to the counter under check.
- enable  input  1  count enable as driven to the counter under check.
- count_in  input  WIDTH  counter output under check.
- clear_stats  input  1  synchronous clear of err_count and sticky_err.
- locked  output  1  checker has seen LOCK_CYCLES consecutive correct predictions.
- error  output  1  one-cycle pulse on a mismatch while locked.
- sticky_err  output  1  set by error; held until clear_stats or reset.
- err_count  output  ERR_W  number of error pulses, saturating.
- expected  output  WIDTH  prediction for count_in at the next edge.
- wrap  output  1  one-cycle pulse when a locked, enabled step goes from all-ones to 0.

Behaviour:
- Reset (asynchronous, active-high): state = IDLE, match_cnt = 0, all outputs 0, history registers (c_q, e_q, r_q) = 0.
- Sampling: at each edge the checker captures c_q <= count_in, e_q <= enable, r_q <= cnt_rst.
- Prediction: pred = r_q ? 0 : (e_q ? c_q + 1 mod 2^WIDTH : c_q).
  - cnt_rst has priority over enable.
  - expected is the registered pred and is valid whenever state != IDLE.
- Compare: at edge k+1, count_in is compared with pred built from the edge-k samples. Checker latency is 1 cycle after the faulty counter output appears.
- State IDLE:
  - First edge after reset only captures history.
  - Next state ACQUIRE, match_cnt = 0.
- State ACQUIRE:
  - Match: match_cnt++.
  - Mismatch: match_cnt = 0 and the checker re-syncs to the observed value; no error, no err_count change.
  - When match_cnt reaches LOCK_CYCLES: go to LOCKED; locked = 1 registered on that edge.
- State LOCKED:
  - Match: stay in LOCKED.
  - Mismatch: error = 1 for one cycle, sticky_err = 1, err_count++ (saturates at 2^ERR_W − 1). Next state ACQUIRE, match_cnt = 0, locked = 0 on the same edge.
- wrap: asserted for one cycle when state is LOCKED, the sample matches, e_q = 1, r_q = 0 and c_q = all-ones (count_in = 0).
- cnt_rst while locked: the counter is expected to read 0 at the next edge. A reset is a legal transition, not an error. Lock is kept.
- clear_stats:
  - Clears err_count and sticky_err on the edge.
  - If a mismatch occurs on the same edge, the clear wins: err_count = 0, sticky_err = 0, but error still pulses.
  - Does not affect lock state.
- Asynchronous reset mid-operation: immediate return to IDLE with all outputs 0, regardless of clock.
- Hold with enable = 0: the prediction is the held value; any change in count_in is a mismatch.

Test Plan:
- Async reset at t = 5, release at 15; counter enabled at 25 → locked = 1 two edges after the first valid compare, error never asserted, err_count = 0.
- Enabled run from 0 through 15 to 0 → exactly one wrap pulse, on the edge where count_in = 0 follows 15; expected tracks count_in + 1.
- While locked, force count_in = 7 when 5 is expected → error pulses one cycle after the bad value, sticky_err = 1, err_count = 1, locked drops; locked returns after 2 correct steps.
- cnt_rst asserted for one edge mid-count at value 9 → next count_in = 0 is accepted, locked stays 1, no error; enable = 0 hold at 3 with count_in stable → no error.
- 300 injected mismatches with ERR_W = 8 → err_count saturates at 255. clear_stats coincident with a mismatch → err_count = 0, sticky_err = 0, error still pulses.
- Assert reset asynchronously between edges while locked → all outputs 0 immediately; after release, IDLE capture then ACQUIRE, relock after LOCK_CYCLES matches.

Source files
------------

// File: rtl/counter_checker.sv
// counter_checker
//   Passive sequence checker for a WIDTH-bit enable counter. It samples the
//   counter's controls and output on every rising edge, predicts the next
//   output value and compares it with what the counter actually produces.
//   It reports lock, mismatch pulses, wrap pulses and a saturating error count.
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous active-high checker reset
//   cnt_rst      synchronous reset seen by the counter under check
//   enable       count enable seen by the counter under check
//   count_in     counter output under check
//   clear_stats  synchronous clear of err_count / sticky_err
//   locked       LOCK_CYCLES consecutive correct predictions seen
//   error        one-cycle pulse on a mismatch while locked
//   sticky_err   set by error, held until clear_stats or reset
//   err_count    number of error pulses, saturating
//   expected     prediction for count_in at the next edge
//   wrap         one-cycle pulse on a locked all-ones -> 0 step
module counter_checker #(
    parameter int WIDTH       = 4,
    parameter int ERR_W       = 8,
    parameter int LOCK_CYCLES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cnt_rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] count_in,
    input  logic             clear_stats,
    output logic             locked,
    output logic             error,
    output logic             sticky_err,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] expected,
    output logic             wrap
);

    localparam int MC_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [MC_W-1:0] LOCK_N = MC_W'(LOCK_CYCLES);

    typedef enum logic [1:0] {IDLE = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [MC_W-1:0]  match_cnt_q, match_cnt_d;
    logic [WIDTH-1:0] c_q;
    logic             e_q, r_q;
    logic             locked_q, locked_d;
    logic             error_q, error_d;
    logic             sticky_q, sticky_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic             wrap_q, wrap_d;

    logic [WIDTH-1:0] pred;
    logic             match;
    logic             err_hit;

    // Prediction from last edge's samples; counter reset beats enable.
    always_comb begin
        pred = c_q;
        if (r_q)
            pred = '0;
        else if (e_q)
            pred = c_q + WIDTH'(1);
    end

    assign match = (count_in == pred);

    // State register plus all registered outputs and sample history.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            match_cnt_q <= '0;
            c_q         <= '0;
            e_q         <= 1'b0;
            r_q         <= 1'b0;
            locked_q    <= 1'b0;
            error_q     <= 1'b0;
            sticky_q    <= 1'b0;
            err_cnt_q   <= '0;
            exp_q       <= '0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            match_cnt_q <= match_cnt_d;
            c_q         <= count_in;
            e_q         <= enable;
            r_q         <= cnt_rst;
            locked_q    <= locked_d;
            error_q     <= error_d;
            sticky_q    <= sticky_d;
            err_cnt_q   <= err_cnt_d;
            exp_q       <= exp_d;
            wrap_q      <= wrap_d;
        end
    end

    // Next-state logic. A mismatch in ACQUIRE simply restarts the match run;
    // history always follows count_in, so the checker re-syncs for free.
    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        case (state_q)
            IDLE: begin
                state_d     = ACQUIRE;
                match_cnt_d = '0;
            end
            ACQUIRE: begin
                if (match) begin
                    match_cnt_d = match_cnt_q + MC_W'(1);
                    if (match_cnt_q + MC_W'(1) == LOCK_N)
                        state_d = LOCKED;
                end else begin
                    match_cnt_d = '0;
                end
            end
            LOCKED: begin
                if (!match) begin
                    state_d     = ACQUIRE;
                    match_cnt_d = '0;
                end
            end
            default: begin
                state_d     = IDLE;
                match_cnt_d = '0;
            end
        endcase
    end

    // Output logic (registered next values).
    always_comb begin
        err_hit  = (state_q == LOCKED) && !match;
        locked_d = (state_d == LOCKED);
        error_d  = err_hit;

        // clear_stats wins over a coincident error; error itself still pulses.
        sticky_d  = sticky_q | err_hit;
        err_cnt_d = err_cnt_q;
        if (err_hit && (err_cnt_q != {ERR_W{1'b1}}))
            err_cnt_d = err_cnt_q + ERR_W'(1);
        if (clear_stats) begin
            sticky_d  = 1'b0;
            err_cnt_d = '0;
        end

        wrap_d = (state_q == LOCKED) && match && e_q && !r_q && (c_q == {WIDTH{1'b1}});

        // Prediction for the next edge, built from this edge's inputs.
        exp_d = count_in;
        if (cnt_rst)
            exp_d = '0;
        else if (enable)
            exp_d = count_in + WIDTH'(1);
    end

    assign locked     = locked_q;
    assign error      = error_q;
    assign sticky_err = sticky_q;
    assign err_count  = err_cnt_q;
    assign expected   = exp_q;
    assign wrap       = wrap_q;

endmodule

// File: tb/tb_counter_checker.sv
// Directed bench for counter_checker: the bench plays the counter under check
// (cnt) and drives count_in, overriding it to inject faults.
module tb_counter_checker;

    logic       clock, reset, cnt_rst, enable, clear_stats;
    logic [3:0] count_in;
    logic       locked, error, sticky_err, wrap;
    logic [7:0] err_count;
    logic [3:0] expected;

    int   checks = 0;
    int   errors = 0;
    logic [3:0] cnt;
    logic [3:0] samp;
    int   wraps;

    counter_checker #(.WIDTH(4), .ERR_W(8), .LOCK_CYCLES(2)) dut (
        .clock(clock), .reset(reset), .cnt_rst(cnt_rst), .enable(enable),
        .count_in(count_in), .clear_stats(clear_stats), .locked(locked),
        .error(error), .sticky_err(sticky_err), .err_count(err_count),
        .expected(expected), .wrap(wrap)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One correct counter step.
    task automatic cstep(input logic en, input logic cr);
        enable  = en;
        cnt_rst = cr;
        tick();
        cnt      = cr ? 4'd0 : (en ? cnt + 4'd1 : cnt);
        count_in = cnt;
    endtask

    // One faulty value on count_in (enable held high), then the counter
    // carries on from the faulty value.
    task automatic inject_bad();
        enable   = 1'b1;
        cnt_rst  = 1'b0;
        count_in = cnt ^ 4'h8;
        tick();
        cnt      = (cnt ^ 4'h8) + 4'd1;
        count_in = cnt;
    endtask

    task automatic relock();
        cstep(1'b1, 1'b0);
        cstep(1'b1, 1'b0);
    endtask

    initial begin
        reset = 1'b0; cnt_rst = 1'b0; enable = 1'b1; clear_stats = 1'b0;
        cnt = 4'd0; count_in = 4'd0;

        // Reset, spanning the first edge.
        #2 reset = 1'b1;
        #6;
        chk("rst_locked", locked, 0);
        chk("rst_error", error, 0);
        chk("rst_errcnt", err_count, 0);
        chk("rst_expected", expected, 0);
        chk("rst_wrap", wrap, 0);
        #4 reset = 1'b0;

        // Acquire: IDLE capture, then two matches.
        cstep(1'b1, 1'b0);
        chk("acq_e1_locked", locked, 0);
        chk("acq_e1_expected", expected, 1);
        cstep(1'b1, 1'b0);
        chk("acq_e2_locked", locked, 0);
        cstep(1'b1, 1'b0);
        chk("acq_e3_locked", locked, 1);
        chk("acq_e3_error", error, 0);
        chk("acq_e3_errcnt", err_count, 0);

        // Enabled run through 15 -> 0: exactly one wrap.
        wraps = 0;
        for (int i = 0; i < 20; i++) begin
            samp = count_in;
            cstep(1'b1, 1'b0);
            chk("run_wrap", wrap, (samp == 4'd0 ? 1 : 0));
            chk("run_expected", expected, cnt);
            chk("run_error", error, 0);
            if (wrap) wraps++;
        end
        chk("run_wrap_count", wraps, 1);

        // Fault: 7 shows up where 5 is due.
        for (int i = 0; i < 16 && cnt != 4'd4; i++) cstep(1'b1, 1'b0);
        enable = 1'b1;
        tick();
        count_in = 4'd7;
        cnt = 4'd7;
        chk("flt_pre_error", error, 0);
        chk("flt_pre_expected", expected, 5);
        cstep(1'b1, 1'b0);
        chk("flt_error", error, 1);
        chk("flt_sticky", sticky_err, 1);
        chk("flt_errcnt", err_count, 1);
        chk("flt_locked", locked, 0);
        cstep(1'b1, 1'b0);
        chk("flt_error_pulse", error, 0);
        chk("flt_relock1", locked, 0);
        cstep(1'b1, 1'b0);
        chk("flt_relock2", locked, 1);
        chk("flt_sticky_hold", sticky_err, 1);

        // cnt_rst at 9 is a legal step.
        for (int i = 0; i < 16 && cnt != 4'd9; i++) cstep(1'b1, 1'b0);
        cstep(1'b1, 1'b1);
        chk("crst_expected", expected, 0);
        chk("crst_locked", locked, 1);
        cstep(1'b1, 1'b0);
        chk("crst_next_locked", locked, 1);
        chk("crst_next_error", error, 0);
        chk("crst_next_expected", expected, 1);

        // Hold at 3 with enable low.
        for (int i = 0; i < 16 && cnt != 4'd3; i++) cstep(1'b1, 1'b0);
        cstep(1'b0, 1'b0);
        chk("hold_expected", expected, 3);
        cstep(1'b0, 1'b0);
        cstep(1'b0, 1'b0);
        chk("hold_error", error, 0);
        chk("hold_locked", locked, 1);
        chk("hold_errcnt", err_count, 1);
        // A change while holding is a mismatch.
        enable = 1'b0;
        count_in = 4'd4;
        cnt = 4'd4;
        tick();
        chk("hold_chg_error", error, 1);
        chk("hold_chg_errcnt", err_count, 2);
        relock();
        chk("hold_relock", locked, 1);

        // Saturation.
        for (int i = 0; i < 100; i++) begin inject_bad(); relock(); end
        chk("sat_102", err_count, 102);
        chk("sat_locked", locked, 1);
        for (int i = 0; i < 200; i++) begin inject_bad(); relock(); end
        chk("sat_255", err_count, 255);
        chk("sat_sticky", sticky_err, 1);

        // clear_stats together with a mismatch.
        clear_stats = 1'b1;
        inject_bad();
        clear_stats = 1'b0;
        chk("clr_mm_error", error, 1);
        chk("clr_mm_errcnt", err_count, 0);
        chk("clr_mm_sticky", sticky_err, 0);
        chk("clr_mm_locked", locked, 0);
        relock();
        chk("clr_mm_relock", locked, 1);
        chk("clr_mm_errcnt2", err_count, 0);

        // clear_stats alone keeps lock.
        inject_bad();
        relock();
        chk("clr_pre_errcnt", err_count, 1);
        clear_stats = 1'b1;
        cstep(1'b1, 1'b0);
        clear_stats = 1'b0;
        chk("clr_errcnt", err_count, 0);
        chk("clr_sticky", sticky_err, 0);
        chk("clr_locked", locked, 1);

        // Async reset between edges while locked.
        inject_bad();
        relock();
        for (int i = 0; i < 16 && cnt == 4'd0; i++) cstep(1'b1, 1'b0);
        chk("ar_pre_sticky", sticky_err, 1);
        #2 reset = 1'b1;
        #1;
        chk("ar_locked", locked, 0);
        chk("ar_error", error, 0);
        chk("ar_sticky", sticky_err, 0);
        chk("ar_errcnt", err_count, 0);
        chk("ar_expected", expected, 0);
        chk("ar_wrap", wrap, 0);
        #1 reset = 1'b0;
        cnt = 4'd5;
        count_in = 4'd5;
        cstep(1'b1, 1'b0);
        chk("ar_idle_locked", locked, 0);
        chk("ar_idle_error", error, 0);
        chk("ar_idle_expected", expected, 6);
        cstep(1'b1, 1'b0);
        chk("ar_acq_locked", locked, 0);
        cstep(1'b1, 1'b0);
        chk("ar_relock", locked, 1);
        chk("ar_relock_errcnt", err_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
